// File: rtl/sram_arbiter.sv
// sram_arbiter
// Arbitrates the single-port frame SRAM between the fill engine (F) and the
// alpha blender (A). Round-robin between two req/gnt requesters, locked bursts
// with an idle timeout, and per-requester enables from the main controller.
// Writes stream at one access per cycle. A read holds the SRAM until its data
// returns to the owner. Every output comes straight from a register.
module sram_arbiter #(
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 1536,
    parameter int READ_LAT = 2,
    parameter int LOCK_TO  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fill_en,
    input  logic              alpha_en,
    input  logic              f_req,
    input  logic              a_req,
    input  logic              f_we,
    input  logic              a_we,
    input  logic              f_lock,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] f_wdata,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              f_gnt,
    output logic              a_gnt,
    output logic              f_rvalid,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] read_data,
    output logic              read_enable,
    output logic              write_enable,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    output logic              busy
);

    localparam int LAT_W = $clog2(READ_LAT + 1);
    localparam int TO_W  = $clog2(LOCK_TO + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RD_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        REQ_F = 1'b0,
        REQ_A = 1'b1
    } req_id_t;

    state_t           r_state;
    req_id_t          r_rr;          // preferred requester when both are eligible
    req_id_t          r_owner;       // owner of the access in flight
    req_id_t          r_lock_owner;
    logic             r_locked;
    logic             r_we;          // command in ACCESS is a write
    logic [LAT_W-1:0] r_lat_cnt;
    logic [TO_W-1:0]  r_to_cnt;

    logic              w_eff_f;
    logic              w_eff_a;
    logic              w_elig_f;
    logic              w_elig_a;
    logic              w_win_valid;
    logic              w_arb_en;
    logic              w_owner_en;
    logic              w_owner_eff;
    req_id_t           w_win;
    req_id_t           w_lose;
    logic              w_win_we;
    logic              w_win_lock;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;

    // A request only counts while the controller enables that requester.
    assign w_eff_f = f_req & fill_en;
    assign w_eff_a = a_req & alpha_en;

    assign w_owner_en  = (r_lock_owner == REQ_F) ? fill_en : alpha_en;
    assign w_owner_eff = (r_lock_owner == REQ_F) ? w_eff_f : w_eff_a;

    // While a lock is held only its owner may win.
    assign w_elig_f    = w_eff_f & (~r_locked | (r_lock_owner == REQ_F));
    assign w_elig_a    = w_eff_a & (~r_locked | (r_lock_owner == REQ_A));
    assign w_win_valid = w_elig_f | w_elig_a;

    // Arbitration runs when idle, and in ACCESS behind a write so writes stream.
    assign w_arb_en = (r_state == S_IDLE) | ((r_state == S_ACCESS) & r_we);

    // Pick the winner and mux its command onto the candidate bus.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can leave a latch.
        w_win       = REQ_F;
        w_win_we    = f_we;
        w_win_lock  = f_lock;
        w_win_addr  = f_addr;
        w_win_wdata = f_wdata;
        if (w_elig_f & w_elig_a) begin
            w_win = r_rr;
        end else if (w_elig_a) begin
            w_win = REQ_A;
        end
        if (w_win == REQ_A) begin
            w_win_we    = a_we;
            w_win_lock  = a_lock;
            w_win_addr  = a_addr;
            w_win_wdata = a_wdata;
        end
        w_lose = (w_win == REQ_F) ? REQ_A : REQ_F;
    end

    // Sequencer FSM: lock bookkeeping, read wait, arbitration and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rr         <= REQ_F;
            r_owner      <= REQ_F;
            r_lock_owner <= REQ_F;
            r_locked     <= 1'b0;
            r_we         <= 1'b0;
            r_lat_cnt    <= '0;
            r_to_cnt     <= '0;
            f_gnt        <= 1'b0;
            a_gnt        <= 1'b0;
            f_rvalid     <= 1'b0;
            a_rvalid     <= 1'b0;
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            busy         <= 1'b0;
            address      <= '0;
            write_data   <= '0;
            rdata        <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments only; a later assignment in this block wins.
            f_gnt        <= 1'b0;
            a_gnt        <= 1'b0;
            f_rvalid     <= 1'b0;
            a_rvalid     <= 1'b0;
            read_enable  <= 1'b0;
            write_enable <= 1'b0;

            // Lock release: the owner lost its enable, or it stayed away too long while idle.
            if (r_locked) begin
                if (!w_owner_en) begin
                    r_locked <= 1'b0;
                    r_to_cnt <= '0;
                end else if (w_owner_eff) begin
                    r_to_cnt <= '0;
                end else if (r_state == S_IDLE) begin
                    if (r_to_cnt == TO_W'(LOCK_TO - 1)) begin
                        r_locked <= 1'b0;
                        r_to_cnt <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
            end else begin
                r_to_cnt <= '0;
            end

            case (r_state)
                S_ACCESS: begin
                    if (!r_we) begin
                        r_state   <= S_RD_WAIT;
                        r_lat_cnt <= LAT_W'(1);
                        busy      <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                S_RD_WAIT: begin
                    if (r_lat_cnt == LAT_W'(READ_LAT)) begin
                        rdata   <= read_data;
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        if (r_owner == REQ_F) begin
                            f_rvalid <= 1'b1;
                        end else begin
                            a_rvalid <= 1'b1;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase

            // A grant overrides the state and lock updates above.
            if (w_arb_en && w_win_valid) begin
                r_state      <= S_ACCESS;
                busy         <= 1'b1;
                r_owner      <= w_win;
                r_we         <= w_win_we;
                r_rr         <= w_lose;
                r_locked     <= w_win_lock;
                r_lock_owner <= w_win;
                r_to_cnt     <= '0;
                address      <= w_win_addr;
                write_data   <= w_win_wdata;
                write_enable <= w_win_we;
                read_enable  <= ~w_win_we;
                if (w_win == REQ_F) begin
                    f_gnt <= 1'b1;
                end else begin
                    a_gnt <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
// Scoreboard bench: each test queues requester commands and the grants (with
// exact cycle) it expects. A negedge monitor pops and compares every grant,
// strobe, read return and rdata value. A small pipelined SRAM model returns
// an address-dependent pattern READ_LAT cycles after read_enable.
module tb_sram_arbiter;

    localparam int ADDR_W   = 24;
    localparam int DATA_W   = 1536;
    localparam int READ_LAT = 2;
    localparam int LOCK_TO  = 8;
    localparam bit ID_F     = 1'b0;
    localparam bit ID_A     = 1'b1;

    logic              clk = 1'b0;
    logic              rst;
    logic              fill_en;
    logic              alpha_en;
    logic              f_req;
    logic              a_req;
    logic              f_we;
    logic              a_we;
    logic              f_lock;
    logic              a_lock;
    logic [ADDR_W-1:0] f_addr;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] f_wdata;
    logic [DATA_W-1:0] a_wdata;
    logic              f_gnt;
    logic              a_gnt;
    logic              f_rvalid;
    logic              a_rvalid;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] read_data;
    logic              read_enable;
    logic              write_enable;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic              busy;

    typedef struct {
        bit                we;
        bit                lock;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct {
        bit                who;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                cyc;
    } exp_gnt_t;

    typedef struct {
        bit                who;
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_rd_t;

    cmd_t     f_cmds[$];
    cmd_t     a_cmds[$];
    exp_gnt_t exp_q[$];
    exp_rd_t  rd_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    logic [DATA_W-1:0] rd_pipe [READ_LAT];

    sram_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .READ_LAT(READ_LAT),
        .LOCK_TO (LOCK_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fill_en     (fill_en),
        .alpha_en    (alpha_en),
        .f_req       (f_req),
        .a_req       (a_req),
        .f_we        (f_we),
        .a_we        (a_we),
        .f_lock      (f_lock),
        .a_lock      (a_lock),
        .f_addr      (f_addr),
        .a_addr      (a_addr),
        .f_wdata     (f_wdata),
        .a_wdata     (a_wdata),
        .f_gnt       (f_gnt),
        .a_gnt       (a_gnt),
        .f_rvalid    (f_rvalid),
        .a_rvalid    (a_rvalid),
        .rdata       (rdata),
        .read_data   (read_data),
        .read_enable (read_enable),
        .write_enable(write_enable),
        .address     (address),
        .write_data  (write_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM content seen by reads: a fixed 0xABCD pattern with the address folded into the low bits.
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] p;
        p = {(DATA_W/16){16'hABCD}};
        p[ADDR_W-1:0] = p[ADDR_W-1:0] ^ a;
        return p;
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        for (int k = 0; k < DATA_W/32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    // SRAM model: data for a read strobe appears on read_data READ_LAT cycles later.
    always @(posedge clk) begin
        rd_pipe[0] <= (read_enable === 1'b1) ? pattern(address) : '0;
        for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign read_data = rd_pipe[READ_LAT-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input bit who, input bit we, input bit lock,
                        input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        cmd_t c;
        c.we = we; c.lock = lock; c.addr = addr; c.wdata = wdata;
        if (who == ID_A) a_cmds.push_back(c);
        else             f_cmds.push_back(c);
    endtask

    task automatic expect_gnt(input bit who, input bit we, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] wdata, input int at);
        exp_gnt_t e;
        e.who = who; e.we = we; e.addr = addr; e.wdata = wdata; e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || rd_q.size() != 0) && n < 100) begin
            at_neg();
            n++;
        end
        check("drain", 64'(exp_q.size() + rd_q.size()), 64'd0);
        at_neg();
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_gnt"},    64'({a_gnt, f_gnt}), 64'd0);
        check({pfx, "_rvalid"}, 64'({a_rvalid, f_rvalid}), 64'd0);
        check({pfx, "_strobe"}, 64'({read_enable, write_enable}), 64'd0);
        check({pfx, "_busy"},   64'(busy), 64'd0);
        check({pfx, "_addr"},   64'(address), 64'd0);
        check({pfx, "_wdata"},  64'(write_data === '0), 64'd1);
        check({pfx, "_rdata"},  64'(rdata === '0), 64'd1);
    endtask

    task automatic reset_dut();
        at_neg();
        rst = 1'b1;
        f_cmds.delete(); a_cmds.delete(); exp_q.delete(); rd_q.delete();
        at_neg();
        at_neg();
        rst = 1'b0;
    endtask

    // Fill-engine requester: holds its command until gnt, then presents the next one.
    initial begin
        f_req = 1'b0; f_we = 1'b0; f_lock = 1'b0; f_addr = '0; f_wdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (f_gnt === 1'b1 && f_cmds.size() > 0) void'(f_cmds.pop_front());
            if (f_cmds.size() > 0) begin
                f_req = 1'b1; f_we = f_cmds[0].we; f_lock = f_cmds[0].lock;
                f_addr = f_cmds[0].addr; f_wdata = f_cmds[0].wdata;
            end else begin
                f_req = 1'b0;
            end
        end
    end

    // Alpha-blender requester: same handshake as the fill engine.
    initial begin
        a_req = 1'b0; a_we = 1'b0; a_lock = 1'b0; a_addr = '0; a_wdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (a_gnt === 1'b1 && a_cmds.size() > 0) void'(a_cmds.pop_front());
            if (a_cmds.size() > 0) begin
                a_req = 1'b1; a_we = a_cmds[0].we; a_lock = a_cmds[0].lock;
                a_addr = a_cmds[0].addr; a_wdata = a_cmds[0].wdata;
            end else begin
                a_req = 1'b0;
            end
        end
    end

    // Monitor: every cycle compares grants/strobes and read returns against the scoreboard.
    initial begin : monitor
        exp_gnt_t e;
        exp_rd_t  r;
        logic [1:0] exp_g;
        logic [1:0] exp_r;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                exp_g = 2'b00;
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) exp_g = exp_q[0].who ? 2'b10 : 2'b01;
                check("gnt", 64'({a_gnt, f_gnt}), 64'(exp_g));
                if (exp_g != 2'b00) begin
                    e = exp_q.pop_front();
                    check("write_enable", 64'(write_enable), 64'(e.we));
                    check("read_enable",  64'(read_enable), 64'(!e.we));
                    check("address",      64'(address), 64'(e.addr));
                    check("write_data",   64'(write_data === e.wdata), 64'd1);
                    check("busy_access",  64'(busy), 64'd1);
                    if (!e.we) begin
                        r.who = e.who; r.data = pattern(e.addr); r.cyc = cyc + READ_LAT + 1;
                        rd_q.push_back(r);
                    end
                end else begin
                    check("idle_strobes", 64'({read_enable, write_enable}), 64'd0);
                end

                exp_r = 2'b00;
                if (rd_q.size() > 0 && rd_q[0].cyc == cyc) exp_r = rd_q[0].who ? 2'b10 : 2'b01;
                check("rvalid", 64'({a_rvalid, f_rvalid}), 64'(exp_r));
                if (exp_r != 2'b00) begin
                    r = rd_q.pop_front();
                    check("rdata_lo", rdata[63:0], r.data[63:0]);
                    check("rdata",    64'(rdata === r.data), 64'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin : main
        int c;
        logic [DATA_W-1:0] d;
        rst = 1'b1; fill_en = 1'b1; alpha_en = 1'b1;
        repeat (3) @(posedge clk);
        at_neg();
        check_zero("reset");
        rst = 1'b0;
        mon_en = 1'b1;

        // Single F write of all-ones to 0x10.
        at_neg(); c = cyc;
        d = '1;
        send(ID_F, 1'b1, 1'b0, 24'h000010, d);
        expect_gnt(ID_F, 1'b1, 24'h000010, d, c + 2);
        wait_drain();

        // Single A read from 0x20: strobe, then rvalid READ_LAT+1 cycles later.
        at_neg(); c = cyc;
        send(ID_A, 1'b0, 1'b0, 24'h000020, '0);
        expect_gnt(ID_A, 1'b0, 24'h000020, '0, c + 2);
        wait_drain();

        // Both stream writes after reset: F,A,F,A... one per cycle.
        reset_dut();
        at_neg(); c = cyc;
        for (int i = 0; i < 4; i++) begin
            d = rand_data();
            send(ID_F, 1'b1, 1'b0, 24'h000100 + 24'(i), d);
            expect_gnt(ID_F, 1'b1, 24'h000100 + 24'(i), d, c + 2 + 2*i);
            d = rand_data();
            send(ID_A, 1'b1, 1'b0, 24'h000200 + 24'(i), d);
            expect_gnt(ID_A, 1'b1, 24'h000200 + 24'(i), d, c + 3 + 2*i);
        end
        wait_drain();

        // F locked burst (lock 1,1,0) keeps A out until the unlocked write.
        reset_dut();
        at_neg(); c = cyc;
        for (int i = 0; i < 3; i++) begin
            d = rand_data();
            send(ID_F, 1'b1, (i < 2), 24'h000300 + 24'(i), d);
            expect_gnt(ID_F, 1'b1, 24'h000300 + 24'(i), d, c + 2 + i);
        end
        d = rand_data();
        send(ID_A, 1'b1, 1'b0, 24'h000400, d);
        expect_gnt(ID_A, 1'b1, 24'h000400, d, c + 5);
        wait_drain();

        // Abandoned F lock: A waits LOCK_TO idle cycles.
        reset_dut();
        at_neg(); c = cyc;
        d = rand_data();
        send(ID_F, 1'b1, 1'b1, 24'h000500, d);
        expect_gnt(ID_F, 1'b1, 24'h000500, d, c + 2);
        d = rand_data();
        send(ID_A, 1'b1, 1'b0, 24'h000600, d);
        expect_gnt(ID_A, 1'b1, 24'h000600, d, c + LOCK_TO + 4);
        wait_drain();

        // Dropping fill_en releases F's lock at once.
        reset_dut();
        at_neg(); c = cyc;
        d = rand_data();
        send(ID_F, 1'b1, 1'b1, 24'h000580, d);
        expect_gnt(ID_F, 1'b1, 24'h000580, d, c + 2);
        d = rand_data();
        send(ID_A, 1'b1, 1'b0, 24'h000680, d);
        while (cyc < c + 2) at_neg();
        fill_en = 1'b0;
        expect_gnt(ID_A, 1'b1, 24'h000680, d, c + 4);
        wait_drain();
        fill_en = 1'b1;

        // Reset during RD_WAIT drops the read; a fresh read is then served normally.
        reset_dut();
        at_neg(); c = cyc;
        send(ID_F, 1'b0, 1'b0, 24'h000700, '0);
        expect_gnt(ID_F, 1'b0, 24'h000700, '0, c + 2);
        while (cyc < c + 3) at_neg();
        check("busy_rd_wait", 64'(busy), 64'd1);
        rst = 1'b1;
        rd_q.delete();
        at_neg();
        check_zero("midread_rst");
        rst = 1'b0;
        c = cyc;
        send(ID_F, 1'b0, 1'b0, 24'h000710, '0);
        expect_gnt(ID_F, 1'b0, 24'h000710, '0, c + 2);
        wait_drain();

        // A held off for 20 cycles by alpha_en=0, granted right after enable.
        reset_dut();
        at_neg();
        alpha_en = 1'b0;
        d = rand_data();
        send(ID_A, 1'b1, 1'b0, 24'h000800, d);
        repeat (20) at_neg();
        c = cyc;
        expect_gnt(ID_A, 1'b1, 24'h000800, d, c + 1);
        alpha_en = 1'b1;
        wait_drain();

        repeat (3) at_neg();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
